// File: rtl/stoch_pkg.sv
// Shared types and helpers for the stochastic datapath (decoder and number generator).
package stoch_pkg;

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_e;

  localparam int DEF_LOG2_LEN = 8;

  function automatic int unsigned win_len(input int unsigned log2);
    return 32'd1 << log2;
  endfunction

endpackage

// File: rtl/stoch_window_cnt.sv
// Window sample counter: synchronous clear/increment under enable, flags the last sample slot.
module stoch_window_cnt #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (clr_i) begin
        cnt_d = '0;
      end else if (inc_i) begin
        // Rolls over from all-ones to zero exactly at the window boundary.
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == {W{1'b1}});

endmodule

// File: rtl/stoch_to_bin_decoder.sv
// Counts ones of a stochastic bitstream over 2**LOG2_LEN accepted samples, publishes result with a done pulse.
// Build option STOCH_BIPOLAR_EN: report signed bipolar value 2*count - 2**LOG2_LEN instead of the raw count.
module stoch_to_bin_decoder
  import stoch_pkg::*;
#(
  parameter  int LOG2_LEN = DEF_LOG2_LEN,
  localparam int RES_W    = LOG2_LEN + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result
);

  state_e              state_q, state_d;
  logic [LOG2_LEN:0]   acc_q, acc_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                done_q, done_d;

  logic                is_idle;
  logic                is_accum;
  logic                win_clr;
  logic                accept;
  logic                last;
  logic [LOG2_LEN:0]   acc_fin;
  logic [RES_W-1:0]    res_fin;

  assign is_idle  = (state_q == S_IDLE);
  assign is_accum = (state_q == S_ACCUM);
  assign win_clr  = ena & start & is_idle;
  assign accept   = ena & bit_valid & is_accum;
  assign acc_fin  = acc_q + {{LOG2_LEN{1'b0}}, bit_in};

`ifdef STOCH_BIPOLAR_EN
  assign res_fin = {acc_fin, 1'b0} - RES_W'(win_len(LOG2_LEN));
`else
  assign res_fin = {1'b0, acc_fin};
`endif

  stoch_window_cnt #(
    .W (LOG2_LEN)
  ) u_win_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (ena),
    .clr_i  (win_clr),
    .inc_i  (accept),
    .last_o (last)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = done_q;
    // With ena low everything holds, so a pending done pulse stretches rather than vanishing.
    if (ena) begin
      done_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_ACCUM;
            acc_d   = '0;
          end
        end
        S_ACCUM: begin
          if (bit_valid) begin
            acc_d = acc_fin;
            if (last) begin
              state_d  = S_IDLE;
              result_d = res_fin;
              done_d   = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = is_accum;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_stoch_to_bin_decoder.sv
// Scoreboard bench for stoch_to_bin_decoder with a 16-sample window.
module tb_stoch_to_bin_decoder;

  localparam int LOG2_LEN = 4;
  localparam int WIN      = 16;
  localparam int RES_W    = LOG2_LEN + 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic             start;
  logic             bit_in;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic [RES_W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic done_prev = 1'b0;
  logic [RES_W-1:0] exp_q[$];
  logic [RES_W-1:0] last_exp = '0;

  stoch_to_bin_decoder #(.LOG2_LEN(LOG2_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  function automatic logic [RES_W-1:0] exp_of(input int ones);
`ifdef STOCH_BIPOLAR_EN
    return RES_W'(2 * ones - WIN);
`else
    return RES_W'(ones);
`endif
  endfunction

  // Output monitor: every done pulse pops one expected window result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        done_cnt++;
        n_checks++;
        if (done_prev) begin
          n_fail++;
          $display("FAIL done_width: done high for two consecutive cycles");
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: result=%0h with empty scoreboard", result);
        end else begin
          logic [RES_W-1:0] e;
          e = exp_q.pop_front();
          last_exp = e;
          if (result !== e) begin
            n_fail++;
            $display("FAIL window_result: got %0h expected %0h", result, e);
          end
        end
      end
      done_prev <= done;
    end else begin
      done_prev <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_window(input logic [WIN-1:0] bits, input bit push);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (push) exp_q.push_back(exp_of($countones(bits)));
  endtask

  task automatic send_sample(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      bit_valid = 1'b0;
      bit_in    = 1'(g);
      tick();
    end
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic check_window_end(input string name, input int done_before);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_end: done=%b busy=%b expected done=1 busy=0", name, done, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || done_cnt != done_before + 1) begin
      n_fail++;
      $display("FAIL %s_pulse: done=%b done_cnt=%0d expected done=0 done_cnt=%0d",
               name, done, done_cnt, done_before + 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    #12;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b result=%0h expected 0 0 0", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_all_ones();
    logic [WIN-1:0] bits;
    int d0;
    bits = '1;
    d0 = done_cnt;
    begin_window(bits, 1'b1);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ones_busy: busy=%b expected 1", busy);
    end
    for (int i = 0; i < WIN; i++) send_sample(bits[i], 0);
    check_window_end("ones", d0);
  endtask

  task automatic test_alternating();
    logic [WIN-1:0] bits;
    int d0;
    int busy_cycles;
    bits = 16'h5555;
    d0 = done_cnt;
    busy_cycles = 0;
    begin_window(bits, 1'b1);
    for (int i = 0; i < WIN; i++) begin
      if (busy) busy_cycles++;
      send_sample(bits[i], 0);
    end
    n_checks++;
    if (busy_cycles != WIN) begin
      n_fail++;
      $display("FAIL alt_busy_cycles: got %0d expected %0d", busy_cycles, WIN);
    end
    check_window_end("alt", d0);
  endtask

  task automatic test_zero_then_ones();
    logic [WIN-1:0] bits;
    int d0;
    bits = '0;
    d0 = done_cnt;
    begin_window(bits, 1'b1);
    for (int i = 0; i < WIN; i++) send_sample(bits[i], 0);
    check_window_end("zero", d0);
    bits = '1;
    d0 = done_cnt;
    begin_window(bits, 1'b1);
    for (int i = 0; i < WIN; i++) begin
      send_sample(bits[i], 0);
      if (i == 7) begin
        n_checks++;
        if (result !== exp_of(0)) begin
          n_fail++;
          $display("FAIL result_hold: got %0h expected %0h", result, exp_of(0));
        end
      end
    end
    check_window_end("refill", d0);
  endtask

  task automatic test_sparse_valid();
    logic [WIN-1:0] bits;
    int d0;
    bits = 16'b0000_1001_0010_0101;
    d0 = done_cnt;
    begin_window(bits, 1'b1);
    for (int i = 0; i < WIN; i++) begin
      send_sample(bits[i], 2);
      if (i < WIN - 1) begin
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL sparse_early: sample %0d done=%b busy=%b expected 0 1", i, done, busy);
        end
      end
    end
    check_window_end("sparse", d0);
  endtask

  task automatic test_start_and_ena();
    logic [WIN-1:0] bits;
    int d0;
    bits = 16'hA3C1;
    d0 = done_cnt;
    begin_window(bits, 1'b1);
    for (int i = 0; i < WIN; i++) begin
      if (i == 5) start = 1'b1;
      send_sample(bits[i], 0);
      start = 1'b0;
      if (i == 9) begin
        ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
          bit_valid = 1'b1;
          bit_in    = 1'b1;
          start     = 1'b1;
          tick();
        end
        bit_valid = 1'b0;
        start     = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL ena_freeze: busy=%b done=%b expected 1 0", busy, done);
        end
        ena = 1'b1;
      end
    end
    check_window_end("restart_ena", d0);
  endtask

  task automatic test_midwindow_reset();
    logic [WIN-1:0] bits;
    int d0;
    bits = '1;
    begin_window(bits, 1'b0);
    for (int i = 0; i < 7; i++) send_sample(bits[i], 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      n_fail++;
      $display("FAIL midreset: busy=%b done=%b result=%0h expected 0 0 0", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 20; i++) send_sample(1'b1, 0);
    n_checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: done_cnt=%0d busy=%b expected %0d 0", done_cnt, busy, d0);
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_alternating();
    test_zero_then_ones();
    test_sparse_valid();
    test_start_and_ena();
    test_midwindow_reset();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results never produced, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
